// File: rtl/prog_mem_ctrl_pkg.sv
// Shared types and constants for the self-programmable program memory controller.
package prog_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY1,
    ST_ARMED,
    ST_BUSY
  } pm_state_e;

  // Two-byte unlock sequence that must precede every single write.
  localparam logic [7:0] KEY_FIRST  = 8'h55;
  localparam logic [7:0] KEY_SECOND = 8'hAA;

  // Instruction word presented to the CPU while the array is being programmed.
  localparam int NOP_WORD = 0;

endpackage

// File: rtl/prog_mem_ctrl_if.sv
// CPU-side fetch and self-programming bus of the program memory controller.
interface prog_mem_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 14
);
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_wdata;
  logic              pm_rd_req;
  logic [DATA_W-1:0] pm_rdata;
  logic [7:0]        pm_key;
  logic              pm_key_vld;
  logic              pm_wr_req;
  logic              pm_busy;
  logic              pm_err;
  logic              pm_err_clr;

  modport master (
    output fetch_addr, pm_addr, pm_wdata, pm_rd_req, pm_key, pm_key_vld,
           pm_wr_req, pm_err_clr,
    input  fetch_data, fetch_valid, pm_rdata, pm_busy, pm_err
  );

  modport slave (
    input  fetch_addr, pm_addr, pm_wdata, pm_rd_req, pm_key, pm_key_vld,
           pm_wr_req, pm_err_clr,
    output fetch_data, fetch_valid, pm_rdata, pm_busy, pm_err
  );
endinterface

// File: rtl/prog_mem_array.sv
// Storage array: one always-on synchronous read port, one enabled read port, one write port.
module prog_mem_array #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 14,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic a_in, b_in, w_in;
  assign a_in = 32'(a_addr) < 32'(DEPTH);
  assign b_in = 32'(b_addr) < 32'(DEPTH);
  assign w_in = 32'(w_addr) < 32'(DEPTH);

  // Contents are deliberately not reset; only the output registers are.
  always_ff @(posedge clk) begin
    if (we && w_in) mem[w_addr] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= a_in ? mem[a_addr] : '0;
      if (b_en) b_rdata <= b_in ? mem[b_addr] : '0;
    end
  end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: instruction fetch plus key-protected self-programming.
module prog_mem_ctrl
  import prog_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 14,
  parameter int DEPTH     = 2**ADDR_W,
  parameter int WR_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  prog_mem_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(WR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);

  pm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              fetch_vld_q;
  logic              err_q;
  logic              busy, last_busy, capture, err_set;
  logic [DATA_W-1:0] a_rdata;

  assign busy      = (state_q == ST_BUSY);
  assign last_busy = busy && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pm_key_vld && bus.pm_key == KEY_FIRST) state_d = ST_KEY1;
        if (bus.pm_wr_req) err_set = 1'b1;
      end
      ST_KEY1: begin
        if (bus.pm_key_vld) begin
          if (bus.pm_key == KEY_SECOND) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end
        end
        if (bus.pm_wr_req) err_set = 1'b1;
      end
      ST_ARMED: begin
        // A stray key byte while armed aborts the unlock rather than writing.
        if (bus.pm_key_vld) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else if (bus.pm_wr_req) begin
          state_d = ST_BUSY;
          capture = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        if (bus.pm_wr_req) err_set = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.pm_rd_req && busy) err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fetch_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= (busy && cnt_q != CNT_LAST) ? cnt_q + CNT_W'(1) : '0;
      fetch_vld_q <= !busy;
      if (capture) begin
        wr_addr_q <= bus.pm_addr;
        wr_data_q <= bus.pm_wdata;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (err_set)             err_q <= 1'b1;
      else if (bus.pm_err_clr) err_q <= 1'b0;
    end
  end

  prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_addr  (bus.fetch_addr),
    .a_rdata (a_rdata),
    .b_en    (bus.pm_rd_req && !busy),
    .b_addr  (bus.pm_addr),
    .b_rdata (bus.pm_rdata),
    .we      (last_busy),
    .w_addr  (wr_addr_q),
    .w_data  (wr_data_q)
  );

  // The fetch register reflects the previous cycle; also masking by the current
  // busy keeps the first programming cycle from leaking a stale word.
  assign bus.fetch_valid = fetch_vld_q && !busy;
  assign bus.fetch_data  = bus.fetch_valid ? a_rdata : DATA_W'(NOP_WORD);
  assign bus.pm_busy     = busy;
  assign bus.pm_err      = err_q;

endmodule

// File: doc/prog_mem_ctrl.md
PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

Interface
REQ-001 Parameters: ADDR_W default 11 (word address width); DATA_W default 14 (instruction width); DEPTH default 2**ADDR_W (words stored); WR_CYCLES default 4 (programming busy duration, cycles, >=1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 fetch_addr  input  ADDR_W  instruction fetch address.
REQ-005 fetch_data  output  DATA_W  registered instruction word.
REQ-006 fetch_valid  output  1  fetch_data holds a valid word for the previous cycle's fetch_addr.
REQ-007 pm_addr  input  ADDR_W  self-program read/write address.
REQ-008 pm_wdata  input  DATA_W  self-program write data.
REQ-009 pm_rd_req  input  1  one-cycle read strobe.
REQ-010 pm_rdata  output  DATA_W  registered read data.
REQ-011 pm_key  input  8  unlock key byte; pm_key_vld  input  1  key strobe.
REQ-012 pm_wr_req  input  1  one-cycle write strobe.
REQ-013 pm_busy  output  1  write in progress; CPU stalls while high.
REQ-014 pm_err  output  1  sticky error; pm_err_clr  input  1  clears it.

Function
REQ-015 Storage: DEPTH x DATA_W array; addresses >= DEPTH read 0 and ignore writes.
REQ-016 Fetch: fetch_data = mem[fetch_addr] one cycle after presentation; fetch_valid = 1 whenever pm_busy was 0 in that cycle.
REQ-017 While pm_busy = 1, fetch_data = 0 (NOP) and fetch_valid = 0.
REQ-018 Read: pm_rd_req sampled high with pm_busy = 0 loads pm_rdata = mem[pm_addr] next cycle; otherwise pm_rdata holds; pm_rd_req during busy sets pm_err.
REQ-019 Unlock FSM states: IDLE, KEY1, ARMED, BUSY.
REQ-020 IDLE: pm_key_vld with pm_key = 8'h55 -> KEY1; any other key -> IDLE.
REQ-021 KEY1: next pm_key_vld with 8'hAA -> ARMED; any other key -> IDLE and pm_err set; cycles without pm_key_vld hold KEY1.
REQ-022 ARMED: pm_wr_req -> capture pm_addr/pm_wdata, enter BUSY; pm_key_vld -> IDLE and pm_err set.
REQ-023 pm_wr_req in IDLE or KEY1 sets pm_err, no write, state unchanged.
REQ-024 BUSY: pm_busy = 1 for exactly WR_CYCLES cycles; array written with captured data on the last BUSY cycle; then IDLE (lock re-armed per write).
REQ-025 Inputs pm_key_vld, pm_wr_req during BUSY ignored except pm_wr_req sets pm_err.
REQ-026 Fetch to the address being written returns new data only from the first cycle after BUSY exits.
REQ-027 pm_err_clr and a new error in the same cycle: error wins (pm_err = 1).
REQ-028 Busy counter width = clog2(WR_CYCLES+1); no wrap beyond WR_CYCLES.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, counter 0, pm_busy 0, pm_err 0, fetch_valid 0, fetch_data 0, pm_rdata 0.
REQ-030 Array contents not reset; reset mid-BUSY aborts the write and leaves target word unchanged.
REQ-031 Deassertion of rst_n takes effect on the next rising clk edge.

Structure
REQ-032 Shared package holds FSM state enum, key constants 8'h55/8'hAA, NOP word constant.
REQ-033 One sub-module prog_mem_array (synchronous dual-read, single-write array) instantiated inside prog_mem_ctrl; FSM and counter in the top.

Verification
REQ-034 Preload mem[0x005]=14'h0103; fetch_addr=0x005 -> fetch_data=14'h0103, fetch_valid=1 next cycle.
REQ-035 Keys 0x55, 0xAA, pm_wr_req addr 0x010 data 14'h3FFF -> pm_busy high 4 cycles, fetch_valid 0, then pm_rd_req 0x010 returns 14'h3FFF.
REQ-036 pm_wr_req without keys -> pm_err=1, mem[0x010] unchanged, pm_busy stays 0.
REQ-037 Keys 0x55, 0x12 -> state IDLE, pm_err=1; pm_err_clr -> pm_err=0 next cycle.
REQ-038 rst_n low at BUSY cycle 2 -> outputs reset immediately, mem[target] retains old value.
REQ-039 ADDR_W=8, DATA_W=16, WR_CYCLES=1 build: write/readback at 0xFF passes, busy exactly 1 cycle.
